uart_tx_arb: RTL and testbench

UART_TX_ARB -- requirements
Module: uart_tx_arb

---
 rtl/uart_pkg.sv | 27 ++
 rtl/rr_pick.sv | 30 +++
 rtl/uart_tx_arb.sv | 128 ++++++++++++
 tb/tb_uart_tx_arb.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART transmit arbiter.
//   state_t  - arbiter FSM encoding (IDLE, ISSUE, WAIT)
//   TMO_W    - minimum width of the WAIT timeout counter
//   MAX_REQ  - largest supported requester count
//   oh2idx   - one-hot to binary index conversion (up to MAX_REQ bits)
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    localparam int TMO_W   = 16;
    localparam int MAX_REQ = 8;

    // OR-reduction form: no priority chain, the input is assumed one-hot.
    function automatic logic [2:0] oh2idx(input logic [MAX_REQ-1:0] oh);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_REQ; i++) begin
            if (oh[i]) idx = idx | 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin selector.
//   req  [NREQ] - request vector
//   last [IW]   - index of the previous owner; search starts at last+1
//   pick [NREQ] - one-hot winner, all-zero when no request is set
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last,
    output logic [NREQ-1:0] pick
);

    always_comb begin
        logic found;
        int   idx;
        pick  = '0;
        found = 1'b0;
        idx   = 0;
        // k runs 1..NREQ so the previous owner is checked last.
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(last) + k) % NREQ;
            if (!found && req[idx]) begin
                pick[idx] = 1'b1;
                found     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arb.sv
// uart_tx_arb: arbitrates NREQ requester channels onto one shared UART
// transmitter. One character at a time: accept (IDLE), strobe the
// transmitter (ISSUE), then wait for the completion edge or a timeout (WAIT).
//   clk, rst            - clock, synchronous active-high reset
//   req_valid/req_data  - per-channel character offer (DBITS per channel)
//   req_lock            - keep the grant for the next character
//   req_ready           - one-hot accept, combinational, IDLE only
//   sent                - one-cycle completion pulse on the owning channel
//   grant               - one-hot current owner, zero when idle
//   tx_din/tx_start     - registered character and start strobe
//   tx_done             - transmitter completion, rising edge significant
//   busy                - high outside IDLE
//   tmo_err             - one-cycle pulse when a character times out
module uart_tx_arb
    import uart_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int DBITS = 8,
    parameter int TMO   = 65535
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*DBITS-1:0] req_data,
    input  logic [NREQ-1:0]       req_lock,
    output logic [NREQ-1:0]       req_ready,
    output logic [NREQ-1:0]       sent,
    output logic [NREQ-1:0]       grant,
    output logic [DBITS-1:0]      tx_din,
    output logic                  tx_start,
    input  logic                  tx_done,
    output logic                  busy,
    output logic                  tmo_err
);

    localparam int IW = $clog2(NREQ);
    localparam int CW = ($clog2(TMO + 1) > TMO_W) ? $clog2(TMO + 1) : TMO_W;

    state_t          state;
    logic [IW-1:0]   last_owner;
    logic            lock_q;
    logic [CW-1:0]   cnt;
    logic            tx_done_q;

    logic [NREQ-1:0] rr_sel;
    logic [NREQ-1:0] pick;
    logic [IW-1:0]   pick_idx;
    logic [IW-1:0]   own_idx;
    logic            use_lock;
    logic            done_rise;

    rr_pick #(.NREQ(NREQ), .IW(IW)) u_rr (
        .req  (req_valid),
        .last (last_owner),
        .pick (rr_sel)
    );

    // A locked previous owner that still has data bypasses round-robin.
    assign use_lock  = lock_q & req_valid[last_owner];
    assign pick      = use_lock ? (NREQ'(1) << last_owner) : rr_sel;
    assign pick_idx  = IW'(oh2idx(MAX_REQ'(pick)));
    assign own_idx   = IW'(oh2idx(MAX_REQ'(grant)));
    assign done_rise = tx_done & ~tx_done_q;

    assign req_ready = (state == IDLE && !rst) ? pick : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            grant      <= '0;
            sent       <= '0;
            tx_start   <= 1'b0;
            tmo_err    <= 1'b0;
            busy       <= 1'b0;
            tx_din     <= '0;
            last_owner <= IW'(NREQ - 1);
            lock_q     <= 1'b0;
            cnt        <= '0;
            tx_done_q  <= 1'b0;
        end else begin
            sent     <= '0;
            tx_start <= 1'b0;
            tmo_err  <= 1'b0;
            // Sampling every cycle also primes the detector during ISSUE,
            // so a level already high on WAIT entry is not a completion.
            tx_done_q <= tx_done;
            case (state)
                IDLE: begin
                    if (lock_q && !req_valid[last_owner]) lock_q <= 1'b0;
                    if (|req_valid) begin
                        state    <= ISSUE;
                        grant    <= pick;
                        tx_din   <= req_data[pick_idx*DBITS +: DBITS];
                        tx_start <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                ISSUE: begin
                    state <= WAIT;
                    cnt   <= '0;
                end
                WAIT: begin
                    if (done_rise) begin
                        sent       <= grant;
                        last_owner <= own_idx;
                        lock_q     <= req_lock[own_idx];
                        grant      <= '0;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end else if (cnt == CW'(TMO - 1)) begin
                        // Abort: owner still advances so a stuck channel
                        // cannot monopolise the transmitter.
                        tmo_err    <= 1'b1;
                        last_owner <= own_idx;
                        lock_q     <= 1'b0;
                        grant      <= '0;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arb.sv
// tb_uart_tx_arb: directed self-checking bench for uart_tx_arb
// (NREQ=4, DBITS=8, TMO=100).
module tb_uart_tx_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_lock;
    logic [3:0]  req_ready;
    logic [3:0]  sent;
    logic [3:0]  grant;
    logic [7:0]  tx_din;
    logic        tx_start;
    logic        tx_done;
    logic        busy;
    logic        tmo_err;

    logic        tx_auto   = 1'b0;
    logic        done_auto = 1'b0;
    logic        done_man  = 1'b0;

    int nchk = 0;
    int nerr = 0;
    int cyc  = 0;

    int sent_idx[$];
    int sent_cyc[$];
    int ts_cyc[$];
    int ts_gnt[$];
    int tmo_cyc[$];

    assign tx_done = tx_auto ? done_auto : done_man;

    uart_tx_arb #(.NREQ(4), .DBITS(8), .TMO(100)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_lock  (req_lock),
        .req_ready (req_ready),
        .sent      (sent),
        .grant     (grant),
        .tx_din    (tx_din),
        .tx_start  (tx_start),
        .tx_done   (tx_done),
        .busy      (busy),
        .tmo_err   (tmo_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int oh_idx(input logic [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return i;
        return -1;
    endfunction

    always @(negedge clk) begin
        if (|sent) begin
            sent_idx.push_back(oh_idx(sent));
            sent_cyc.push_back(cyc);
        end
        if (tx_start) begin
            ts_cyc.push_back(cyc);
            ts_gnt.push_back(oh_idx(grant));
        end
        if (tmo_err) tmo_cyc.push_back(cyc);
    end

    // Transmitter stand-in: tx_done pulses 20 cycles after each tx_start.
    always begin
        @(posedge clk); #1;
        if (tx_auto && tx_start) begin
            repeat (20) @(posedge clk);
            #1 done_auto = 1'b1;
            @(posedge clk);
            #1 done_auto = 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic clear_logs();
        sent_idx.delete(); sent_cyc.delete();
        ts_cyc.delete(); ts_gnt.delete(); tmo_cyc.delete();
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((busy || tx_start) && n < 200) begin tick(); n++; end
        check("drain_idle", 32'(busy), 32'd0);
        repeat (3) tick();
    endtask

    initial begin
        int n;
        rst = 1'b1; req_valid = '0; req_data = '0; req_lock = '0;
        tick(); tick();

        // Reset state; req_ready must stay low while rst is high.
        req_valid = 4'hf; #1;
        check("rst_grant",   32'(grant),     32'd0);
        check("rst_busy",    32'(busy),      32'd0);
        check("rst_start",   32'(tx_start),  32'd0);
        check("rst_sent",    32'(sent),      32'd0);
        check("rst_tmo",     32'(tmo_err),   32'd0);
        check("rst_din",     32'(tx_din),    32'd0);
        check("rst_ready",   32'(req_ready), 32'd0);

        // First accept after reset goes to channel 0.
        rst = 1'b0; req_data = 32'h44332211; #1;
        check("t1_ready", 32'(req_ready), 32'h1);
        tick();
        check("t1_start", 32'(tx_start),  32'd1);
        check("t1_din",   32'(tx_din),    32'h11);
        check("t1_grant", 32'(grant),     32'h1);
        check("t1_busy",  32'(busy),      32'd1);
        check("t1_ready_issue", 32'(req_ready), 32'd0);
        req_valid = 4'h0; req_data = 32'hdeadbeef;
        tick();
        check("t1_start_off", 32'(tx_start), 32'd0);
        check("t1_din_hold",  32'(tx_din),   32'h11);
        check("t1_grant_hold", 32'(grant),   32'h1);
        done_man = 1'b1;
        tick();
        check("t1_sent",     32'(sent),  32'h1);
        check("t1_grant_rel", 32'(grant), 32'd0);
        check("t1_busy_rel", 32'(busy),  32'd0);
        done_man = 1'b0;
        tick();
        check("t1_sent_pulse", 32'(sent), 32'd0);

        // Round-robin under continuous load.
        do_reset();
        clear_logs();
        tx_auto = 1'b1; req_lock = '0; req_data = 32'h44332211; req_valid = 4'hf;
        n = 0;
        while (sent_idx.size() < 5 && n < 600) begin tick(); n++; end
        req_valid = 4'h0;
        drain();
        tx_auto = 1'b0;
        check("t2_nsent", 32'(sent_idx.size() >= 5), 32'd1);
        if (sent_idx.size() >= 5 && ts_cyc.size() >= 5) begin
            check("t2_order0", 32'(sent_idx[0]), 32'd0);
            check("t2_order1", 32'(sent_idx[1]), 32'd1);
            check("t2_order2", 32'(sent_idx[2]), 32'd2);
            check("t2_order3", 32'(sent_idx[3]), 32'd3);
            check("t2_order4", 32'(sent_idx[4]), 32'd0);
            check("t2_lat", 32'(sent_cyc[0] - ts_cyc[0]), 32'd21);
            for (int i = 0; i < 4; i++)
                check($sformatf("t2_gap%0d", i), 32'(ts_cyc[i+1] - sent_cyc[i]), 32'd1);
        end

        // Lock keeps channel 2 for three characters.
        do_reset();
        clear_logs();
        tx_auto = 1'b1; req_lock = 4'b0100; req_valid = 4'b0100;
        n = 0;
        while (ts_cyc.size() < 1 && n < 100) begin tick(); n++; end
        req_valid = 4'b0101;
        n = 0;
        while (ts_cyc.size() < 3 && n < 200) begin tick(); n++; end
        req_lock = 4'b0000;
        n = 0;
        while (ts_cyc.size() < 4 && n < 100) begin tick(); n++; end
        req_valid = 4'h0;
        drain();
        tx_auto = 1'b0;
        check("t3_nstart", 32'(ts_gnt.size()), 32'd4);
        if (ts_gnt.size() >= 4) begin
            check("t3_g0", 32'(ts_gnt[0]), 32'd2);
            check("t3_g1", 32'(ts_gnt[1]), 32'd2);
            check("t3_g2", 32'(ts_gnt[2]), 32'd2);
            check("t3_g3", 32'(ts_gnt[3]), 32'd0);
        end

        // Timeout: tx_done already high on WAIT entry, never toggles.
        do_reset();
        clear_logs();
        done_man = 1'b1; req_valid = 4'hf;
        n = 0;
        while (tmo_cyc.size() < 1 && n < 300) begin tick(); n++; end
        check("t4_tmo_seen", 32'(tmo_cyc.size()), 32'd1);
        if (tmo_cyc.size() >= 1 && ts_cyc.size() >= 1)
            check("t4_tmo_time", 32'(tmo_cyc[0] - ts_cyc[0]), 32'd101);
        check("t4_no_sent", 32'(sent_idx.size()), 32'd0);
        n = 0;
        while (ts_cyc.size() < 2 && n < 10) begin tick(); n++; end
        check("t4_nstart", 32'(ts_gnt.size()), 32'd2);
        if (ts_gnt.size() >= 2) begin
            check("t4_g0", 32'(ts_gnt[0]), 32'd0);
            check("t4_g1", 32'(ts_gnt[1]), 32'd1);
        end
        done_man = 1'b0;
        do_reset();

        // Reset in the middle of WAIT.
        clear_logs();
        req_valid = 4'b0010;
        n = 0;
        while (ts_cyc.size() < 1 && n < 10) begin tick(); n++; end
        req_valid = 4'h0;
        repeat (5) tick();
        check("t5_busy",  32'(busy),  32'd1);
        check("t5_grant", 32'(grant), 32'h2);
        rst = 1'b1;
        tick();
        check("t5_grant0", 32'(grant),     32'd0);
        check("t5_busy0",  32'(busy),      32'd0);
        check("t5_start0", 32'(tx_start),  32'd0);
        check("t5_sent0",  32'(sent),      32'd0);
        check("t5_tmo0",   32'(tmo_err),   32'd0);
        check("t5_din0",   32'(tx_din),    32'd0);
        check("t5_ready0", 32'(req_ready), 32'd0);
        rst = 1'b0; done_man = 1'b1; req_valid = 4'b1001; #1;
        check("t5_ready", 32'(req_ready), 32'h1);
        tick();
        check("t5_regrant", 32'(grant), 32'h1);
        done_man = 1'b0; req_valid = 4'h0;
        repeat (5) tick();
        check("t5_no_sent", 32'(sent_idx.size()), 32'd0);
        check("t5_no_tmo",  32'(tmo_cyc.size()),  32'd0);
        do_reset();

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
